tic_sat_array: RTL
==================

# tic_sat_array

Parametrised N×N weight-stationary systolic matrix-vector engine. It is the next-generation TiC-SAT accelerator tile, generalised in array size, data width and output depth. It accepts packed activation vectors or weight rows over a valid/ready stream, handles input skew and output deskew internally, and requantises each column result to DW bits with saturation. Results go out through a buffered valid/ready port with credit-based admission, so the systolic pipeline never stalls.

## Interface
- N, 4, array dimension (rows = columns = lanes), ≥2
- DW, 8, signed activation/weight/output lane width
- DEPTH, 8, output FIFO entries, power of two, ≥2
- SHIFT, 0, arithmetic right shift applied to accumulators before saturation, 0..2*DW-1
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_mode  in  1  0 = activation vector, 1 = weight-row load
- in_row  in  clog2(N)  weight row index (mode 1 only)
- in_data  in  N*DW  lane i = bits [i*DW +: DW], signed
- out_valid  out  1  out_data holds a result
- out_ready  in  1  consumer pops when out_valid & out_ready
- out_data  out  N*DW  lane c = requantised y[c]
- busy  out  1  1 while any vector is in flight
- sat_flag  out  1  sticky: some lane has saturated since reset

## Operation
- Weight store W[r][c] (N×N × DW). A mode-1 beat writes row in_row: W[in_row][c] = lane c.
- Mode-0 beat: vector a enters. Row r receives a[r] after r skew registers. PE(r,c) registers a rightward and psum downward: psum += a*W[r][c].
- Column c bottom output is delayed N-1-c cycles (deskew). All lanes align, and the vector is pushed into the output FIFO.
- y[c] = Σ_r a[r]*W[r][c]. Product width 2*DW signed; accumulator AW = 2*DW + clog2(N), so no internal overflow.
- Requantisation: y >>> SHIFT (arithmetic shift, truncate toward −inf), then clamp to [−2^(DW−1), 2^(DW−1)−1]. Any clamp sets sat_flag, which clears only on reset.
- A valid bit travels with each vector through a 2N-stage tag pipeline. Bubble cycles carry zeros and are never pushed.
- inflight counter: +1 on a mode-0 accept, −1 on a FIFO push; both in the same cycle leave it unchanged. busy = (inflight ≠ 0).
- State machine:
  - IDLE: inflight = 0. Weight loads are allowed. A mode-0 accept moves to RUN.
  - RUN: inflight > 0. Weight loads are blocked. Returns to IDLE on the cycle inflight reaches 0.
- in_ready, combinational from in_mode, state and counters (never from in_valid):
  - mode 0: fifo_count + inflight < DEPTH. Same-cycle pops are not credited.
  - mode 1: state == IDLE.
- A load requested in RUN waits, so every in-flight vector completes with the weights it entered with.
- Output FIFO is first-word fall-through. Push and pop in the same cycle leave the count unchanged. Full or empty misuse cannot occur because of the credit rule.
- Reset (asserted at any time, including mid-operation): W = 0, all pipeline and tag registers cleared, inflight = 0, FIFO empty, state IDLE.

## Timing
- Reset values: in_ready = 1 for either mode, out_valid = 0, out_data = 0, busy = 0, sat_flag = 0.
- Latency: a vector accepted at edge t is written to the FIFO at edge t+2N. With the FIFO empty, out_valid = 1 in the cycle following edge t+2N.
- Throughput: one vector per cycle while credits remain. Results leave in acceptance order.
- A weight write takes effect at the accepting edge; a vector accepted on the next cycle uses it.
- sat_flag rises in the same cycle the saturated result becomes FIFO-visible.
- busy falls in the same cycle the last in-flight result is pushed.

## Test plan
- Reset mid-stream (N=4): after reset deasserts, all outputs are 0 and in_ready = 1. No stale result ever appears on out_valid.
- Identity W, SHIFT=0, stream a = [1,2,3,4] → out_data lanes [1,2,3,4]. out_valid rises exactly 2N = 8 cycles after acceptance.
- W all 1; back-to-back vectors [1,1,1,1], [2,2,2,2], [−3,−3,−3,−3] → lanes 4, 8, −12 on three consecutive cycles.
- Saturation:
  - W = 127, a = 127 → every lane 127 and sat_flag = 1.
  - W = 127, a = −128 → every lane −128.
  - SHIFT=8 with W = 16, a = 16 (sum 1024) → lanes 4 and sat_flag stays 0.
- Backpressure (DEPTH=4, out_ready = 0, continuous in_valid) → exactly 4 vectors accepted, then in_ready = 0. Raising out_ready drains them in order with no loss or duplication.
- Weight load requested while busy → in_ready stays 0 until busy falls. Earlier vectors use the old W; a vector accepted after the load uses the new W.

Source files
------------

// File: rtl/tic_sat_array_if.sv
// Stream bundle for tic_sat_array: input beat channel (vectors and weight
// rows) and buffered result channel.
//   in_valid/in_ready/in_mode/in_row/in_data : input beat, mode 0 = vector, 1 = weight row
//   out_valid/out_ready/out_data             : result stream, lane c = y[c]
interface tic_sat_array_if #(
   parameter int unsigned N  = 4,
   parameter int unsigned DW = 8
);
   localparam int unsigned RW = $clog2(N);

   logic            in_valid;
   logic            in_ready;
   logic            in_mode;
   logic [RW-1:0]   in_row;
   logic [N*DW-1:0] in_data;
   logic            out_valid;
   logic            out_ready;
   logic [N*DW-1:0] out_data;

   modport master (
      output in_valid, in_mode, in_row, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_mode, in_row, in_data, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/tic_sat_array.sv
// N x N weight-stationary systolic matrix-vector engine with input skew,
// output deskew, saturating requantisation and a credit-guarded output FIFO.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : tic_sat_array_if slave (input beats in, results out)
//   busy       : a vector is in flight
//   sat_flag   : sticky, some pushed lane has clamped since reset
module tic_sat_array #(
   parameter int unsigned N     = 4,
   parameter int unsigned DW    = 8,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned SHIFT = 0
) (
   input  logic           clk,
   input  logic           reset,
   tic_sat_array_if.slave bus,
   output logic           busy,
   output logic           sat_flag
);
   localparam int unsigned RW   = $clog2(N);
   localparam int unsigned PW   = 2 * DW;
   localparam int unsigned AW   = 2 * DW + $clog2(N);
   localparam int unsigned PTRW = $clog2(DEPTH);
   localparam int unsigned CW   = PTRW + 2;
   localparam int unsigned TW   = 2 * N;
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;
   localparam logic signed [AW-1:0] MAX_V = AW'((1 << (DW - 1)) - 1);
   localparam logic signed [AW-1:0] MIN_V = ~MAX_V;

   logic [0:0]      state, state_nx;
   logic [CW-1:0]   inflight, inflight_nx;
   logic [PTRW:0]   fifo_count;
   logic [PTRW-1:0] wr_ptr, rd_ptr;
   logic            acc_vec, acc_w, push, pop;
   logic [TW-1:0]   tag;

   logic signed [DW-1:0] w      [N][N];
   logic signed [DW-1:0] a_in   [N];
   logic signed [DW-1:0] a_q    [N][N-1];
   logic signed [DW-1:0] a_pe   [N][N];
   logic signed [AW-1:0] p_q    [N][N];
   logic signed [AW-1:0] p_pe   [N][N];
   logic signed [PW-1:0] prod   [N][N];
   logic signed [AW-1:0] col_out[N];
   logic signed [AW-1:0] shifted[N];
   logic [N-1:0]         sat_lane;
   logic [N*DW-1:0]      res_data;
   logic [N*DW-1:0]      mem [DEPTH];

   // Admission: vectors need a free FIFO credit, weight rows need an empty pipe.
   assign bus.in_ready = bus.in_mode ? (state == S_IDLE)
                                     : ((CW'(fifo_count) + inflight) < CW'(DEPTH));
   assign acc_vec = bus.in_valid & bus.in_ready & ~bus.in_mode;
   assign acc_w   = bus.in_valid & bus.in_ready &  bus.in_mode;

   // Next-state and in-flight bookkeeping.
   always_comb begin
      state_nx    = state;
      inflight_nx = inflight;
      case ({acc_vec, push})
         2'b10:   inflight_nx = inflight + CW'(1);
         2'b01:   inflight_nx = inflight - CW'(1);
         default: ;
      endcase
      case (state)
         S_IDLE:  if (acc_vec) state_nx = S_RUN;
         S_RUN:   if (inflight_nx == '0) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         inflight <= '0;
         busy     <= 1'b0;
      end else begin
         state    <= state_nx;
         inflight <= inflight_nx;
         busy     <= (inflight_nx != '0);
      end
   end

   // Weight store; rows only change while the pipe is empty.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned r = 0; r < N; r++)
            for (int unsigned c = 0; c < N; c++) w[r][c] <= '0;
      end else begin
         for (int unsigned r = 0; r < N; r++)
            for (int unsigned c = 0; c < N; c++)
               if (acc_w && bus.in_row == RW'(r)) w[r][c] <= bus.in_data[c*DW +: DW];
      end
   end

   // Input skew: row r sees its lane r register stages after capture.
   for (genvar r = 0; r < N; r++) begin : g_skew
      logic signed [DW-1:0] sk [r+1];
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            for (int k = 0; k <= r; k++) sk[k] <= '0;
         end else begin
            sk[0] <= acc_vec ? bus.in_data[r*DW +: DW] : '0;
            for (int k = 1; k <= r; k++) sk[k] <= sk[k-1];
         end
      end
      assign a_in[r] = sk[r];
   end

   // PE neighbour wiring: activations flow right, partial sums flow down.
   for (genvar r = 0; r < N; r++) begin : g_row
      for (genvar c = 0; c < N; c++) begin : g_pe
         if (c == 0) begin : g_a0
            assign a_pe[r][c] = a_in[r];
         end else begin : g_an
            assign a_pe[r][c] = a_q[r][c-1];
         end
         if (r == 0) begin : g_p0
            assign p_pe[r][c] = '0;
         end else begin : g_pn
            assign p_pe[r][c] = p_q[r-1][c];
         end
         assign prod[r][c] = PW'(a_pe[r][c]) * PW'(w[r][c]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned c = 0; c < N; c++)     p_q[r][c] <= '0;
            for (int unsigned c = 0; c < N - 1; c++) a_q[r][c] <= '0;
         end
      end else begin
         for (int unsigned r = 0; r < N; r++) begin
            for (int unsigned c = 0; c < N; c++)     p_q[r][c] <= p_pe[r][c] + AW'(prod[r][c]);
            for (int unsigned c = 0; c < N - 1; c++) a_q[r][c] <= a_pe[r][c];
         end
      end
   end

   // Output deskew: column c waits N-1-c cycles so all lanes align.
   for (genvar c = 0; c < N; c++) begin : g_deskew
      if (c == N - 1) begin : g_last
         assign col_out[c] = p_q[N-1][c];
      end else begin : g_dly
         localparam int unsigned DL = N - 1 - c;
         logic signed [AW-1:0] dk [DL];
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               for (int unsigned k = 0; k < DL; k++) dk[k] <= '0;
            end else begin
               dk[0] <= p_q[N-1][c];
               for (int unsigned k = 1; k < DL; k++) dk[k] <= dk[k-1];
            end
         end
         assign col_out[c] = dk[DL-1];
      end
   end

   // Valid tag rides alongside the vector; its last stage is the FIFO push.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) tag <= '0;
      else       tag <= {tag[TW-2:0], acc_vec};
   end
   assign push = tag[TW-1];

   // Requantise: arithmetic shift (floor), then clamp to signed DW range.
   always_comb begin
      sat_lane = '0;
      res_data = '0;
      for (int unsigned c = 0; c < N; c++) begin
         shifted[c] = col_out[c] >>> SHIFT;
         if (shifted[c] > MAX_V) begin
            res_data[c*DW +: DW] = MAX_V[DW-1:0];
            sat_lane[c]          = 1'b1;
         end else if (shifted[c] < MIN_V) begin
            res_data[c*DW +: DW] = MIN_V[DW-1:0];
            sat_lane[c]          = 1'b1;
         end else begin
            res_data[c*DW +: DW] = shifted[c][DW-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) sat_flag <= 1'b0;
      else       sat_flag <= sat_flag | (push & (|sat_lane));
   end

   // First-word fall-through result FIFO; credits guarantee no overflow.
   assign pop           = bus.out_valid & bus.out_ready;
   assign bus.out_valid = (fifo_count != '0);
   assign bus.out_data  = bus.out_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTRW'(1);
         if (pop)  rd_ptr <= rd_ptr + PTRW'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + (PTRW+1)'(1);
            2'b01:   fifo_count <= fifo_count - (PTRW+1)'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= res_data;
   end
endmodule
